// File: rtl/disp_scheduler_if.sv
// Handshake bundle between the display requesters and disp_scheduler.
// master drives requests and tick; slave (the scheduler) drives the mux select side.
interface disp_scheduler_if;
    logic       tick;
    logic [7:0] req;
    logic       manual;
    logic [2:0] man_sel;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       switch;

    modport master (output tick, req, manual, man_sel, input  sel, grant, busy, switch);
    modport slave  (input  tick, req, manual, man_sel, output sel, grant, busy, switch);
endinterface

// File: rtl/disp_scheduler.sv
// Round-robin time-sharing of the 8-channel seven-segment mux with dwell timer and manual override.
// Optional build macro DISP_SCHED_PRIO0_EN makes channel 0 a preempting high-priority channel.
module disp_scheduler #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    disp_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHOW   = 2'd1,
        S_MANUAL = 2'd2
    } state_t;

    state_t           state_r;
    logic [2:0]       sel_r;
    logic [2:0]       sel_d_r;
    logic [2:0]       ptr_r;
    logic [7:0]       grant_r;
    logic             busy_r;
    logic             switch_r;
    logic [CNT_W-1:0] cnt_r;
`ifdef DISP_SCHED_PRIO0_EN
    logic             req0_d_r;
`endif

    logic [3:0]       next_ptr_s;
    logic [3:0]       next_sel_s;
    logic             expire_s;
    logic             prio_hit_s;

    // First set request bit at or above start, wrapping; MSB flags that one was found.
    function automatic logic [3:0] find_next(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] s);
        return 8'd1 << s;
    endfunction

    // Search results, dwell expiry and channel-0 preemption detect.
    always_comb begin
        next_ptr_s = find_next(bus.req, ptr_r + 3'd1);
        next_sel_s = find_next(bus.req, sel_r + 3'd1);
        expire_s   = bus.tick & (cnt_r == CNT_W'(DWELL - 1));
`ifdef DISP_SCHED_PRIO0_EN
        prio_hit_s = bus.req[0] & ~req0_d_r & (sel_r != 3'd0);
`else
        prio_hit_s = 1'b0;
`endif
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            sel_r    <= 3'd0;
            sel_d_r  <= 3'd0;
            ptr_r    <= 3'd7;
            grant_r  <= 8'd0;
            busy_r   <= 1'b0;
            switch_r <= 1'b0;
            cnt_r    <= '0;
`ifdef DISP_SCHED_PRIO0_EN
            req0_d_r <= 1'b0;
`endif
        end else begin
            sel_d_r  <= sel_r;
            switch_r <= (sel_r != sel_d_r);
`ifdef DISP_SCHED_PRIO0_EN
            req0_d_r <= bus.req[0];
`endif
            case (state_r)
                S_IDLE: begin
                    cnt_r <= '0;
                    if (bus.manual) begin
                        state_r <= S_MANUAL;
                        sel_r   <= bus.man_sel;
                        grant_r <= onehot(bus.man_sel);
                        busy_r  <= 1'b1;
                    end else if (bus.req != 8'd0) begin
                        state_r <= S_SHOW;
                        sel_r   <= next_ptr_s[2:0];
                        ptr_r   <= next_ptr_s[2:0];
                        grant_r <= onehot(next_ptr_s[2:0]);
                        busy_r  <= 1'b1;
                    end else begin
                        grant_r <= 8'd0;
                        busy_r  <= 1'b0;
                    end
                end
                S_SHOW: begin
                    if (bus.manual) begin
                        state_r <= S_MANUAL;
                        sel_r   <= bus.man_sel;
                        grant_r <= onehot(bus.man_sel);
                        cnt_r   <= '0;
                    end else if (prio_hit_s) begin
                        sel_r   <= 3'd0;
                        ptr_r   <= 3'd0;
                        grant_r <= 8'd1;
                        cnt_r   <= '0;
                    end else if (!bus.req[sel_r]) begin
                        // A drop wins over a coincident tick; the count restarts either way.
                        cnt_r <= '0;
                        if (next_sel_s[3]) begin
                            sel_r   <= next_sel_s[2:0];
                            ptr_r   <= next_sel_s[2:0];
                            grant_r <= onehot(next_sel_s[2:0]);
                        end else begin
                            state_r <= S_IDLE;
                            grant_r <= 8'd0;
                            busy_r  <= 1'b0;
                        end
                    end else if (expire_s) begin
                        // Search wraps back onto sel, so a lone requester simply keeps the display.
                        cnt_r   <= '0;
                        sel_r   <= next_sel_s[2:0];
                        ptr_r   <= next_sel_s[2:0];
                        grant_r <= onehot(next_sel_s[2:0]);
                    end else if (bus.tick) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_MANUAL: begin
                    cnt_r <= '0;
                    if (bus.manual) begin
                        sel_r   <= bus.man_sel;
                        grant_r <= onehot(bus.man_sel);
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        ptr_r   <= bus.man_sel;
                        grant_r <= 8'd0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    grant_r <= 8'd0;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.sel    = sel_r;
    assign bus.grant  = grant_r;
    assign bus.busy   = busy_r;
    assign bus.switch = switch_r;

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Time-shares the board's single 32-bit, 8-channel seven-segment display path between up to eight data requesters. It drives the channel-select input of the 8-channel display multiplexer, rotating round-robin among active requesters with a programmable dwell time measured in ticks of the clock-divider output. A manual override locks the display to a switch-selected channel.

## Interface
Parameters:
- `DWELL`, default 4: display ticks each granted channel is held; legal range 1..255.
- `CNT_W`, default 8: width of the dwell counter; must satisfy `DWELL <= 2**CNT_W - 1`.

Ports:
- `clk` input 1: system clock; all state on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tick` input 1: one-cycle dwell strobe, synchronous to `clk`, from an edge-detected divider bit.
- `req` input 8: level requests; bit i high means channel i has data to show.
- `manual` input 1: override enable.
- `man_sel` input 3: channel forced while `manual` = 1.
- `sel` output 3: channel select to the display multiplexer.
- `grant` output 8: one-hot grant; all-zero when nothing is shown.
- `busy` output 1: high in SHOW or MANUAL.
- `switch` output 1: one-cycle pulse on the cycle after `sel` changes.

## Operation
- States: IDLE, SHOW, MANUAL. All outputs are registered.
- Reset values: state IDLE, `sel` = 0, `grant` = 0, `busy` = 0, `switch` = 0, dwell count = 0, round-robin pointer = 7. With pointer 7, channel 0 has first priority.
- IDLE:
  - `manual` = 1 → MANUAL.
  - Otherwise, if `req` != 0 → SHOW. The granted channel is the first set `req` bit searching upward from pointer+1, modulo 8.
  - `sel` holds its last value. `grant` = 0.
- SHOW:
  - `grant` = one-hot of `sel`. The count increments on each `tick`.
  - Dwell expiry is `tick` while count = `DWELL`-1. On expiry, search from `sel`+1 for the next set `req` bit:
    - If found and it differs from `sel`: switch to it and clear the count.
    - If the only requester is `sel`: keep `sel`, clear the count, no `switch` pulse.
  - The current channel's `req` drops before expiry: on the next cycle, move to the next requester. If none, go to IDLE.
  - `manual` = 1 → MANUAL, which takes priority over expiry in the same cycle.
- MANUAL:
  - `sel` = `man_sel`, updated every cycle. `grant` = one-hot of `man_sel` whether or not that bit of `req` is set. Count held at 0.
  - `manual` = 0 → IDLE. The pointer is set to `man_sel` so rotation resumes after it.
- Pointer update: the pointer becomes the new `sel` each time SHOW grants a channel.
- Simultaneous `tick` and `req` drop of the current channel: handled as a drop. The count is cleared and any new grant happens once.

## Timing
- `req` rising in IDLE → `grant`/`sel`/`busy` valid on the next rising edge (1-cycle latency).
- Expiry `tick` at edge N → new `sel` at edge N+1 → `switch` high for the cycle after N+1.
- `manual` rising → `sel` = `man_sel` one cycle later.
- A `tick` held high for k cycles counts as k ticks; the source must be a pulse.
- `rst` asserted mid-SHOW clears all outputs immediately, without waiting for a clock edge. The first grant after release follows the reset-pointer rule.

## Configuration
- `DISP_SCHED_PRIO0_EN`
- Defined: channel 0 is the high-priority channel. When `req[0]` rises while SHOW grants another channel, channel 0 preempts it on the next cycle regardless of dwell. After channel 0's dwell or drop, rotation continues from channel 0.
- Undefined: pure round-robin. Channel 0 has no special status.
- MANUAL behaves identically in both builds.

## Test plan
- Reset: assert `rst` mid-SHOW with `sel` = 5 → `sel` = 0, `grant` = 0, `busy` = 0 immediately. First grant after release with `req` = 8'h24 is channel 2.
- Rotation with `DWELL` = 2 and `req` = 8'b1000_0011: grants cycle 0 → 1 → 7 → 0, each held for exactly 2 ticks. One `switch` pulse follows each change.
- Single requester: `req` = 8'h10 for 10 ticks → `sel` stays 4 and `switch` never pulses.
- Drop: `req` = 8'h06 with `sel` = 1; drop `req[1]` → `sel` = 2 next cycle. Then drop `req[2]` → IDLE, `grant` = 0, `sel` holds 2.
- Manual: `manual` = 1 with `man_sel` = 6 and `req` = 0 → `grant` = 8'h40, `busy` = 1. Release with `req` = 8'h41 → next grant is channel 0.
- With `DISP_SCHED_PRIO0_EN`: SHOW on channel 3 at dwell count 0, raise `req[0]` → `sel` = 0 next cycle. Without the macro, channel 3 completes its full dwell first.
